cpu_trace_capture: RTL and testbench

Passive observer on the CPU's debug outputs. Samples register-write, instruction-fetch and PC-write strobes every `CP` cycle and converts each event into a 46-bit trace record. Buffers records in a DEPTH-entry FIFO drained over a valid/ready read port. Detects a halt (branch-to-self) and stops capture. It is the consumer side of the debug port that the CPU drives and benches previously watched only through waveforms.

---
 rtl/cpu_trace_capture_if.sv | 32 +++
 rtl/cpu_trace_capture.sv | 111 +++++++++++
 tb/tb_cpu_trace_capture.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_capture_if.sv
// Debug-port and trace read-port bundle between the CPU side (master) and
// the trace capture block (slave).
interface cpu_trace_capture_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic        enable;
  logic        writePC;
  logic        writeIR;
  logic        writeReg;
  logic [7:0]  PC;
  logic [31:0] IR;
  logic [31:0] F;
  logic [3:0]  nzcv;
  logic        rd_valid;
  logic        rd_ready;
  logic [45:0] rd_data;
  logic [CW-1:0] count;
  logic [7:0]  drop_count;
  logic        halted;

  modport master (
    output enable, writePC, writeIR, writeReg, PC, IR, F, nzcv, rd_ready,
    input  rd_valid, rd_data, count, drop_count, halted
  );

  modport slave (
    input  enable, writePC, writeIR, writeReg, PC, IR, F, nzcv, rd_ready,
    output rd_valid, rd_data, count, drop_count, halted
  );
endinterface

// File: rtl/cpu_trace_capture.sv
// Passive CPU debug-port observer: turns fetch/reg-write/PC-write strobes into
// 46-bit trace records, buffers them in a FIFO and freezes on branch-to-self.
module cpu_trace_capture #(
  parameter int DEPTH       = 16,
  parameter int HALT_REPEAT = 2
) (
  input logic CP,
  input logic reset,
  cpu_trace_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {ST_CAPTURE, ST_HALTED} state_t;

  state_t        state_q, state_d;
  logic [45:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic [7:0]    drop_q;
  logic [7:0]    last_pc;
  logic [3:0]    rep_q;

  logic        empty, full, pop, push, event_v, fetch_rec, halt_hit;
  logic [1:0]  strobe_cnt, n_extra, kind;
  logic [31:0] payload;
  logic [3:0]  rep_next;
  logic [8:0]  drop_sum;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    pop        = !empty && bus.rd_ready;
    event_v    = bus.enable && (state_q == ST_CAPTURE) &&
                 (bus.writeIR || bus.writeReg || bus.writePC);
    push       = event_v && (!full || pop);
    strobe_cnt = {1'b0, bus.writeIR} + {1'b0, bus.writeReg} + {1'b0, bus.writePC};
    n_extra    = event_v ? (strobe_cnt - 2'd1) : 2'd0;
    drop_sum   = {1'b0, drop_q} + {7'd0, n_extra} + {8'd0, (event_v && !push)};

    kind    = 2'b11;
    payload = {24'd0, bus.PC};
    if (bus.writeIR) begin
      kind    = 2'b01;
      payload = bus.IR;
    end else if (bus.writeReg) begin
      kind    = 2'b10;
      payload = bus.F;
    end

    fetch_rec = push && bus.writeIR;
    rep_next  = (bus.PC == last_pc) ? (rep_q + 4'd1) : 4'd1;
    halt_hit  = fetch_rec && (rep_next == 4'(HALT_REPEAT));
  end

  // Dropping enable always releases a halt; otherwise a qualifying fetch halts.
  always_comb begin
    state_d = state_q;
    if (!bus.enable)
      state_d = ST_CAPTURE;
    else if (halt_hit)
      state_d = ST_HALTED;
  end

  always_ff @(posedge CP or posedge reset) begin
    if (reset) state_q <= ST_CAPTURE;
    else       state_q <= state_d;
  end

  // NOTE: the record array is not reset; count gates rd_data, so stale entries are never visible.
  always_ff @(posedge CP) begin
    if (push) mem[wr_ptr] <= {kind, bus.PC, bus.nzcv, payload};
  end

  always_ff @(posedge CP or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_ff @(posedge CP or posedge reset) begin
    if (reset) begin
      rep_q   <= '0;
      last_pc <= '0;
    end else if (!bus.enable) begin
      rep_q <= '0;
    end else if (fetch_rec) begin
      rep_q   <= rep_next;
      last_pc <= bus.PC;
    end
  end

  assign bus.rd_valid   = !empty;
  assign bus.rd_data    = empty ? '0 : mem[rd_ptr];
  assign bus.count      = count_q;
  assign bus.drop_count = drop_q;
  assign bus.halted     = (state_q == ST_HALTED);
endmodule

// File: tb/tb_cpu_trace_capture.sv
// Scoreboard bench for cpu_trace_capture: a behavioural model predicts each
// accepted record, drops and halt, and popped records are compared in order.
module tb_cpu_trace_capture;
  localparam int DEPTH       = 16;
  localparam int HALT_REPEAT = 2;

  logic CP;
  logic reset;

  cpu_trace_capture_if #(.DEPTH(DEPTH)) bus ();

  cpu_trace_capture #(.DEPTH(DEPTH), .HALT_REPEAT(HALT_REPEAT)) dut (
    .CP(CP),
    .reset(reset),
    .bus(bus)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  int total = 0;
  int bad   = 0;

  logic [45:0] sb[$];
  int          m_drops;
  logic        m_halted;
  int          m_rep;
  logic [7:0]  m_last;
  logic        stall_prev;
  logic [45:0] stall_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_drops();
    return (m_drops > 255) ? 255 : m_drops;
  endfunction

  // One clock cycle: observe the read port, drive inputs, advance the model, step the clock.
  task automatic cycle(input logic en, input logic wir, input logic wreg, input logic wpc,
                       input logic rdy, input logic [7:0] pc, input logic [31:0] ir,
                       input logic [31:0] f, input logic [3:0] nz);
    int          pre_size;
    logic        pop;
    logic        ev;
    logic        pushed;
    logic [45:0] exp_rec;
    logic [45:0] rec;
    pre_size = sb.size();
    check("valid", bus.rd_valid, pre_size != 0);
    if (pre_size == 0) check("empty_data", bus.rd_data, 0);
    if (stall_prev) check("stall_hold", bus.rd_data, stall_data);

    bus.enable   = en;
    bus.writeIR  = wir;
    bus.writeReg = wreg;
    bus.writePC  = wpc;
    bus.rd_ready = rdy;
    bus.PC       = pc;
    bus.IR       = ir;
    bus.F        = f;
    bus.nzcv     = nz;

    pop = rdy && (pre_size > 0);
    if (pop) begin
      exp_rec = sb.pop_front();
      check("pop_data", bus.rd_data, exp_rec);
    end
    stall_prev = bus.rd_valid && !rdy;
    stall_data = bus.rd_data;

    pushed = 1'b0;
    ev = en && !m_halted && (wir || wreg || wpc);
    if (ev) begin
      m_drops += int'(wir) + int'(wreg) + int'(wpc) - 1;
      if (wir)       rec = {2'b01, pc, nz, ir};
      else if (wreg) rec = {2'b10, pc, nz, f};
      else           rec = {2'b11, pc, nz, 24'd0, pc};
      if (pre_size == DEPTH && !pop) m_drops++;
      else begin
        sb.push_back(rec);
        pushed = 1'b1;
      end
    end
    if (pushed && wir) begin
      m_rep  = (pc == m_last) ? m_rep + 1 : 1;
      m_last = pc;
      if (m_rep == HALT_REPEAT) m_halted = 1'b1;
    end
    if (!en) begin
      m_halted = 1'b0;
      m_rep    = 0;
    end

    @(posedge CP);
    #1;
    check("count", bus.count, sb.size());
    check("drops", bus.drop_count, sat_drops());
    check("halted", bus.halted, m_halted);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, rdy, 8'h00, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic regw(input logic rdy, input logic [31:0] f);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, rdy, 8'h40, 32'h0, f, 4'h5);
  endtask

  task automatic fetch(input logic [7:0] pc, input logic [31:0] ir);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pc, ir, 32'h0, 4'h2);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4 && sb.size() != 0; i++) idle(1'b1);
    check("drained_count", bus.count, 0);
    check("drained_valid", bus.rd_valid, 0);
  endtask

  // Asserts reset away from the clock edge and checks outputs clear without a clock.
  task automatic do_reset();
    #2;
    reset        = 1'b1;
    bus.writeIR  = 1'b0;
    bus.writeReg = 1'b0;
    bus.writePC  = 1'b0;
    bus.rd_ready = 1'b0;
    #1;
    check("rst_count", bus.count, 0);
    check("rst_valid", bus.rd_valid, 0);
    check("rst_data", bus.rd_data, 0);
    check("rst_drops", bus.drop_count, 0);
    check("rst_halted", bus.halted, 0);
    sb.delete();
    m_drops    = 0;
    m_halted   = 1'b0;
    m_rep      = 0;
    m_last     = 8'h00;
    stall_prev = 1'b0;
    @(negedge CP);
    reset = 1'b0;
    @(posedge CP);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.enable   = 1'b1;
    bus.writeIR  = 1'b0;
    bus.writeReg = 1'b0;
    bus.writePC  = 1'b0;
    bus.rd_ready = 1'b0;
    bus.PC       = '0;
    bus.IR       = '0;
    bus.F        = '0;
    bus.nzcv     = '0;
    m_drops      = 0;
    m_halted     = 1'b0;
    m_rep        = 0;
    m_last       = 8'h00;
    stall_prev   = 1'b0;
    stall_data   = '0;
    repeat (2) @(posedge CP);
    @(negedge CP);
    reset = 1'b0;
    @(posedge CP);
    #1;
    check("init_count", bus.count, 0);
    check("init_valid", bus.rd_valid, 0);
    check("init_data", bus.rd_data, 0);
    check("init_halted", bus.halted, 0);

    // Mid-stream reset with five records queued, then the first capture after release.
    for (int i = 0; i < 5; i++) regw(1'b0, 32'hA0 + i);
    check("pre_reset_count", bus.count, 5);
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 32'hE3A01005, 32'h0, 4'hA);
    check("first_rec", bus.rd_data, {2'b01, 8'h04, 4'hA, 32'hE3A01005});
    check("first_count", bus.count, 1);
    drain();

    // All three strobes together: only the fetch survives.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 32'h11111111, 32'h22222222, 4'h3);
    check("prio_drops", bus.drop_count, 2);
    check("prio_rec", bus.rd_data, {2'b01, 8'h20, 4'h3, 32'h11111111});
    drain();

    // Overfill, then a push that coincides with a pop while full.
    do_reset();
    for (int i = 0; i < 18; i++) regw(1'b0, 32'h100 + i);
    check("full_count", bus.count, 16);
    check("full_drops", bus.drop_count, 2);
    regw(1'b1, 32'h999);
    check("full_pushpop_count", bus.count, 16);
    check("full_pushpop_drops", bus.drop_count, 2);
    drain();

    // Branch-to-self halt, frozen capture, and release through enable.
    do_reset();
    fetch(8'h10, 32'hEA000000);
    fetch(8'h14, 32'hEAFFFFFE);
    fetch(8'h14, 32'hEAFFFFFE);
    check("halt_set", bus.halted, 1);
    check("halt_count", bus.count, 3);
    regw(1'b0, 32'h55);
    check("halt_noreg_count", bus.count, 3);
    check("halt_noreg_drops", bus.drop_count, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h18, 32'h0, 32'h66, 4'h0);
    check("halt_clear", bus.halted, 0);
    check("disabled_drops", bus.drop_count, 0);
    drain();

    // Backpressure: rd_ready toggles each cycle while eight records arrive.
    for (int i = 0; i < 16; i++) begin
      if (i < 8) regw(logic'(i % 2), 32'hB000 + i);
      else       idle(logic'(i % 2));
    end
    drain();

    // Drop counter saturation with the FIFO held full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) regw(1'b0, 32'hC00 + i);
    for (int i = 0; i < 300; i++) regw(1'b0, 32'hD00 + i);
    check("sat_drops", bus.drop_count, 255);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
